// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one registered memory port (mem_*) between I-cache line reads (i_*) and D-cache line reads/write-backs (d_*); clk, async active-high rst
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_nx;
    logic last_d, d_req, grant_d, grant_i;
    assign d_req   = d_read | d_write;
    assign grant_d = d_req & (~i_read | ~last_d);
    assign grant_i = i_read & ~grant_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (grant_i || grant_d)) begin
                last_d    <= grant_d;
                mem_read  <= grant_i | ~d_write;
                mem_write <= grant_d & d_write;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
            end else if (state != IDLE && mem_ready) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    always_comb
        state_nx = (state == IDLE) ? (grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE)
                                   : (mem_ready ? IDLE : state);
    always_comb begin
        i_ready = (state == SERVE_I) && mem_ready;
        d_ready = (state == SERVE_D) && mem_ready;
        i_rdata = (state == SERVE_I) ? mem_rdata : '0;
        d_rdata = (state == SERVE_D) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    logic clk = 1'b0, rst = 1'b1;
    logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic i_ready, d_ready, mem_read, mem_write, mem_ready;
    logic [AW-1:0] mem_addr;
    logic mem_auto = 1'b0, man_ready = 1'b0, auto_ready;
    logic [DW-1:0] man_rdata = '0, auto_rdata;
    int cnt, lat;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );
    assign mem_ready = mem_auto ? auto_ready : man_ready;
    assign mem_rdata = mem_auto ? auto_rdata : man_rdata;
    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    // memory with random 1..4 cycle latency, reset together with the arbiter
    always @(posedge clk or posedge rst)
        if (rst) begin
            auto_ready <= 1'b0;
            auto_rdata <= '0;
            cnt <= 0;
            lat <= 1;
        end else begin
            auto_ready <= 1'b0;
            if ((mem_read || mem_write) && !auto_ready) begin
                if (cnt + 1 >= lat) begin
                    auto_ready <= 1'b1;
                    auto_rdata <= rnd128();
                    cnt <= 0;
                    lat <= int'($urandom_range(1, 4));
                end else cnt <= cnt + 1;
            end
        end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        i_read = 0; d_read = 0; d_write = 0; man_ready = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask
    task automatic test_reset;
        do_reset;
        man_rdata = '1;
        man_ready = 1;
        @(negedge clk);
        checks++; if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, i_ready, d_ready}); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        checks++; if ({mem_wdata, i_rdata, d_rdata} !== '0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", mem_wdata, i_rdata, d_rdata); end
        tick;
        man_ready = 0;
    endtask
    task automatic test_single_i;
        i_addr = 28'h0000040; i_read = 1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL si_latency: mem_read got %b want 0", mem_read); end
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b0, 28'h0000040, {DW{1'b0}}}) begin errors++; $display("FAIL si_grant: got r%b w%b a%h want r1 w0 a0000040", mem_read, mem_write, mem_addr); end
        tick; tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr, i_ready} !== {1'b1, 28'h0000040, 1'b0}) begin errors++; $display("FAIL si_hold: got r%b a%h rdy%b", mem_read, mem_addr, i_ready); end
        tick;
        man_ready = 1; man_rdata = {16{8'hA5}};
        @(negedge clk);
        checks++; if ({i_ready, d_ready, i_rdata, d_rdata} !== {1'b1, 1'b0, {16{8'hA5}}, {DW{1'b0}}}) begin errors++; $display("FAIL si_done: got i%b d%b %h %h", i_ready, d_ready, i_rdata, d_rdata); end
        tick;
        man_ready = 0; i_read = 0;
        @(negedge clk);
        checks++; if ({mem_read, i_ready} !== 2'b00) begin errors++; $display("FAIL si_after: got r%b rdy%b want 00", mem_read, i_ready); end
        tick;
    endtask
    task automatic test_d_write;
        logic [DW-1:0] rd;
        d_addr = 28'h0000100; d_wdata = {4{32'h12345678}}; d_read = 1; d_write = 1;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 28'h0000100, {4{32'h12345678}}}) begin errors++; $display("FAIL dw_grant: got r%b w%b a%h d%h", mem_read, mem_write, mem_addr, mem_wdata); end
        tick;
        rd = rnd128(); man_rdata = rd; man_ready = 1;
        @(negedge clk);
        checks++; if ({d_ready, i_ready, d_rdata} !== {1'b1, 1'b0, rd}) begin errors++; $display("FAIL dw_done: got d%b i%b %h", d_ready, i_ready, d_rdata); end
        tick;
        man_ready = 0; d_read = 0; d_write = 0;
        @(negedge clk);
        checks++; if ({mem_write, d_ready} !== 2'b00) begin errors++; $display("FAIL dw_after: got w%b rdy%b want 00", mem_write, d_ready); end
        tick;
    endtask
    task automatic test_simultaneous;
        do_reset;
        i_addr = 28'h0000111; d_addr = 28'h0000222; i_read = 1; d_read = 1;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000111}) begin errors++; $display("FAIL tie1_first: got r%b a%h want I a0000111", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b10) begin errors++; $display("FAIL tie1_ready: got i%b d%b want 10", i_ready, d_ready); end
        tick;
        man_ready = 0; i_read = 0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL tie1_gap: mem_read got %b want 0", mem_read); end
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000222}) begin errors++; $display("FAIL tie1_second: got r%b a%h want D a0000222", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        tick;
        man_ready = 0; d_read = 0; i_read = 1;
        tick;
        man_ready = 1;
        tick;
        man_ready = 0; i_read = 0;
        tick;
        i_read = 1; d_read = 1;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000222}) begin errors++; $display("FAIL tie2_first: got r%b a%h want D a0000222", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b01) begin errors++; $display("FAIL tie2_ready: got i%b d%b want 01", i_ready, d_ready); end
        tick;
        man_ready = 0; d_read = 0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL tie2_gap: mem_read got %b want 0", mem_read); end
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000111}) begin errors++; $display("FAIL tie2_second: got r%b a%h want I a0000111", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        tick;
        man_ready = 0; i_read = 0;
        tick;
    endtask
    task automatic test_owner_change;
        d_addr = 28'h0000333; d_read = 1; d_write = 0;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000333}) begin errors++; $display("FAIL oc_grant: got r%b a%h", mem_read, mem_addr); end
        tick;
        d_addr = 28'h0000444; d_read = 0; i_addr = 28'h0000555; i_read = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 28'h0000333}) begin errors++; $display("FAIL oc_hold%0d: got r%b w%b a%h", k, mem_read, mem_write, mem_addr); end
            tick;
        end
        man_ready = 1;
        @(negedge clk);
        checks++; if ({d_ready, i_ready} !== 2'b10) begin errors++; $display("FAIL oc_done: got d%b i%b want 10", d_ready, i_ready); end
        tick;
        man_ready = 0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL oc_gap: mem_read got %b want 0", mem_read); end
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000555}) begin errors++; $display("FAIL oc_pending: got r%b a%h want a0000555", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        tick;
        man_ready = 0; i_read = 0;
        tick;
    endtask
    task automatic test_spurious;
        man_ready = 1;
        @(negedge clk);
        checks++; if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL sp_ready: got i%b d%b want 00", i_ready, d_ready); end
        tick;
        man_ready = 0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL sp_strobe: got r%b w%b want 00", mem_read, mem_write); end
        i_addr = 28'h0000066; i_read = 1;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000066}) begin errors++; $display("FAIL sp_idle: got r%b a%h want a0000066", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        tick;
        man_ready = 0; i_read = 0;
        tick;
    endtask
    task automatic test_async_reset;
        d_addr = 28'h0000077; d_wdata = rnd128(); d_write = 1;
        tick;
        @(negedge clk);
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL ar_grant: mem_write got %b want 1", mem_write); end
        #2 rst = 1; man_ready = 1;
        #1;
        checks++; if ({mem_read, mem_write, d_ready, i_ready} !== 4'b0) begin errors++; $display("FAIL ar_drop: got %b want 0000", {mem_read, mem_write, d_ready, i_ready}); end
        man_ready = 0; d_write = 0;
        tick;
        rst = 0; i_addr = 28'h0000088; i_read = 1;
        tick;
        @(negedge clk);
        checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000088}) begin errors++; $display("FAIL ar_regrant: got r%b a%h want a0000088", mem_read, mem_addr); end
        tick;
        man_ready = 1;
        @(negedge clk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL ar_done: i_ready got %b want 1", i_ready); end
        tick;
        man_ready = 0; i_read = 0;
        tick;
    endtask
    // model: one outstanding transaction (owner 0 none, 1 I, 2 D); a tie goes to the side that did not own last
    task automatic test_random(input int n);
        int own, wi, wd;
        bit last_is_d, e_wr, i_done, d_done, s_mr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [1:0] op;
        mem_auto = 1;
        do_reset;
        own = 0; wi = 0; wd = 0; last_is_d = 1; e_wr = 0; e_addr = '0; e_wdata = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_mr = mem_ready;
            checks++; if ({mem_read, mem_write, i_ready, d_ready} !== {own == 1 || (own == 2 && !e_wr), own == 2 && e_wr, own == 1 && s_mr, own == 2 && s_mr}) begin errors++; $display("FAIL rnd_ctl@%0d: got %b owner %0d wr %b", k, {mem_read, mem_write, i_ready, d_ready}, own, e_wr); end
            if (own != 0) begin
                checks++; if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin errors++; $display("FAIL rnd_req@%0d: got a%h d%h want a%h d%h", k, mem_addr, mem_wdata, e_addr, e_wdata); end
            end
            checks++; if ({i_rdata, d_rdata} !== {own == 1 ? mem_rdata : {DW{1'b0}}, own == 2 ? mem_rdata : {DW{1'b0}}}) begin errors++; $display("FAIL rnd_rdata@%0d: got %h %h owner %0d", k, i_rdata, d_rdata, own); end
            tick;
            i_done = 0; d_done = 0;
            if (own != 0) begin
                if (s_mr) begin
                    i_done = own == 1;
                    d_done = own == 2;
                    if (own == 1 && (d_read || d_write)) wd++;
                    if (own == 2 && i_read) wi++;
                    own = 0;
                end
            end else if (i_read || d_read || d_write) begin
                own = ((d_read || d_write) && (!i_read || !last_is_d)) ? 2 : 1;
                last_is_d = own == 2;
                e_wr = own == 2 && d_write;
                e_addr = own == 2 ? d_addr : i_addr;
                e_wdata = own == 2 ? d_wdata : '0;
                checks++; if ((own == 2 ? wd : wi) > 1) begin errors++; $display("FAIL rnd_starve@%0d: owner %0d waited %0d transactions, limit 1", k, own, own == 2 ? wd : wi); end
                if (own == 2) wd = 0; else wi = 0;
            end
            if (i_done) i_read = 0;
            else if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1; i_addr = AW'($urandom); end
            else if (own == 1 && $urandom_range(0, 3) == 0) i_addr = AW'($urandom);
            if (d_done) begin d_read = 0; d_write = 0; end
            else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                op = 2'($urandom_range(1, 3));
                d_read = op[0]; d_write = op[1]; d_addr = AW'($urandom); d_wdata = rnd128();
            end else if (own == 2 && $urandom_range(0, 3) == 0) begin d_addr = AW'($urandom); d_wdata = rnd128(); end
        end
    endtask
    initial begin
        test_reset;
        test_single_i;
        test_d_write;
        test_simultaneous;
        test_owner_change;
        test_spurious;
        test_async_reset;
        test_random(800);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
